// File: rtl/axi_fetch_stage.sv
// Instruction-fetch stage: owns the fetch PC, issues single-beat 64-bit AXI reads,
// and hands {instr, pc, fault} to IF/ID over valid/ready with redirect support.
module axi_fetch_stage #(
    parameter int                ID_WIDTH   = 13,
    parameter int                ADDR_WIDTH = 64,
    parameter int                DATA_WIDTH = 64,
    parameter logic [ID_WIDTH-1:0] FETCH_ID = '0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] entry,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_pc,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [31:0]           out_instr,
    output logic [ADDR_WIDTH-1:0] out_pc,
    output logic                  out_fault,
    output logic [ID_WIDTH-1:0]   m_axi_arid,
    output logic [ADDR_WIDTH-1:0] m_axi_araddr,
    output logic [7:0]            m_axi_arlen,
    output logic [2:0]            m_axi_arsize,
    output logic [1:0]            m_axi_arburst,
    output logic                  m_axi_arlock,
    output logic [3:0]            m_axi_arcache,
    output logic [2:0]            m_axi_arprot,
    output logic                  m_axi_arvalid,
    input  logic                  m_axi_arready,
    input  logic [DATA_WIDTH-1:0] m_axi_rdata,
    input  logic [1:0]            m_axi_rresp,
    input  logic                  m_axi_rlast,
    input  logic                  m_axi_rvalid,
    output logic                  m_axi_rready
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        AR   = 2'd1,
        R    = 2'd2,
        HOLD = 2'd3
    } state_t;

    state_t                  state_reg, state_next;
    logic [ADDR_WIDTH-1:0]   pc_reg, pc_next;
    logic [ADDR_WIDTH-1:0]   araddr_reg, araddr_next;
    logic [ADDR_WIDTH-1:0]   out_pc_reg, out_pc_next;
    logic [31:0]             out_instr_reg, out_instr_next;
    logic                    out_fault_reg, out_fault_next;
    logic                    pending_reg, pending_next;
    logic [ADDR_WIDTH-1:0]   redirect_target;
    logic [31:0]             lane [2];

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_lane
            assign lane[gi] = m_axi_rdata[gi*32 +: 32];
        end
    endgenerate

    assign redirect_target = {redirect_pc[ADDR_WIDTH-1:2], 2'b00};

    logic unused_inputs;
    assign unused_inputs = &{1'b0, redirect_pc[1:0], m_axi_rlast};

    always_comb begin
        state_next     = state_reg;
        pc_next        = pc_reg;
        araddr_next    = araddr_reg;
        out_pc_next    = out_pc_reg;
        out_instr_next = out_instr_reg;
        out_fault_next = out_fault_reg;
        pending_next   = pending_reg;

        case (state_reg)
            IDLE: begin
                state_next = AR;
                if (redirect_valid) pc_next = redirect_target;
            end
            AR: begin
                // The request in flight must finish unchanged; its beat gets dropped later.
                if (redirect_valid) begin
                    pc_next      = redirect_target;
                    pending_next = 1'b1;
                end
                if (m_axi_arready) state_next = R;
            end
            R: begin
                if (redirect_valid) begin
                    pc_next      = redirect_target;
                    pending_next = 1'b1;
                end
                if (m_axi_rvalid) begin
                    pending_next = 1'b0;
                    if (pending_reg || redirect_valid) begin
                        state_next = AR;
                    end else begin
                        out_instr_next = lane[pc_reg[2]];
                        out_pc_next    = pc_reg;
                        out_fault_next = (m_axi_rresp != 2'b00);
                        state_next     = HOLD;
                    end
                end
            end
            HOLD: begin
                // A redirect overrides pc+4 even when the handshake completes this cycle.
                if (redirect_valid) begin
                    pc_next    = redirect_target;
                    state_next = AR;
                end else if (out_ready) begin
                    pc_next    = pc_reg + ADDR_WIDTH'(4);
                    state_next = AR;
                end
            end
            default: state_next = IDLE;
        endcase

        // Address is captured on entry to AR so it cannot move while arvalid is high.
        if (state_next == AR && state_reg != AR)
            araddr_next = {pc_next[ADDR_WIDTH-1:3], 3'b000};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= IDLE;
            pc_reg        <= entry;
            araddr_reg    <= '0;
            out_pc_reg    <= '0;
            out_instr_reg <= '0;
            out_fault_reg <= 1'b0;
            pending_reg   <= 1'b0;
        end else begin
            state_reg     <= state_next;
            pc_reg        <= pc_next;
            araddr_reg    <= araddr_next;
            out_pc_reg    <= out_pc_next;
            out_instr_reg <= out_instr_next;
            out_fault_reg <= out_fault_next;
            pending_reg   <= pending_next;
        end
    end

    assign out_valid     = (state_reg == HOLD);
    assign out_instr     = out_instr_reg;
    assign out_pc        = out_pc_reg;
    assign out_fault     = out_fault_reg;

    assign m_axi_arid    = FETCH_ID;
    assign m_axi_araddr  = araddr_reg;
    assign m_axi_arlen   = 8'd0;
    assign m_axi_arsize  = 3'b011;
    assign m_axi_arburst = 2'b01;
    assign m_axi_arlock  = 1'b0;
    assign m_axi_arcache = 4'd0;
    assign m_axi_arprot  = 3'd0;
    assign m_axi_arvalid = (state_reg == AR);
    assign m_axi_rready  = (state_reg == R);

endmodule

// File: tb/tb_axi_fetch_stage.sv
// Randomized bench for axi_fetch_stage: random-latency AXI slave, random backpressure
// and redirects, and a scoreboard built on the architectural PC sequence.
module tb_axi_fetch_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic [63:0] entry;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [63:0] out_pc;
    logic        out_fault;
    logic [12:0] m_axi_arid;
    logic [63:0] m_axi_araddr;
    logic [7:0]  m_axi_arlen;
    logic [2:0]  m_axi_arsize;
    logic [1:0]  m_axi_arburst;
    logic        m_axi_arlock;
    logic [3:0]  m_axi_arcache;
    logic [2:0]  m_axi_arprot;
    logic        m_axi_arvalid;
    logic        m_axi_arready;
    logic [63:0] m_axi_rdata;
    logic [1:0]  m_axi_rresp;
    logic        m_axi_rlast;
    logic        m_axi_rvalid;
    logic        m_axi_rready;

    always #5 clk = ~clk;

    axi_fetch_stage dut (
        .clk(clk), .reset(reset), .entry(entry),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
        .out_pc(out_pc), .out_fault(out_fault),
        .m_axi_arid(m_axi_arid), .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
        .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst), .m_axi_arlock(m_axi_arlock),
        .m_axi_arcache(m_axi_arcache), .m_axi_arprot(m_axi_arprot),
        .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
        .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp), .m_axi_rlast(m_axi_rlast),
        .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
    );

    int total = 0;
    int bad   = 0;
    int hs_count = 0;

    // Memory contents: a fixed scramble of the 8-byte-aligned address, lanes differ.
    function automatic logic [63:0] mem64(input logic [63:0] a);
        logic [31:0] lo, hi;
        lo = (a[34:3] * 32'h9E37_79B9) ^ 32'h1357_9BDF;
        hi = ((a[34:3] + 32'h55AA_1234) * 32'h0101_0003) ^ 32'hC0DE_0000;
        return {hi, lo};
    endfunction

    function automatic logic fault_at(input logic [63:0] a);
        return a[5:3] == 3'd5;
    endfunction

    task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // AXI slave: random arready, 0..2 cycle read latency, one request at a time.
    initial begin
        logic        hs_ar, hs_r, rst_s, have;
        logic [63:0] ar_addr, req_addr;
        int          delay;
        have = 1'b0; req_addr = '0; delay = 0;
        m_axi_arready = 1'b0; m_axi_rvalid = 1'b0; m_axi_rdata = '0;
        m_axi_rresp = 2'b00; m_axi_rlast = 1'b0;
        forever begin
            @(posedge clk);
            hs_ar   = m_axi_arvalid && m_axi_arready;
            hs_r    = m_axi_rvalid && m_axi_rready;
            ar_addr = m_axi_araddr;
            rst_s   = reset;
            #1;
            if (rst_s) begin
                have = 1'b0;
                m_axi_arready = 1'b0;
                m_axi_rvalid  = 1'b0;
                m_axi_rlast   = 1'b0;
            end else begin
                if (hs_r) begin
                    have = 1'b0;
                    m_axi_rvalid = 1'b0;
                    m_axi_rlast  = 1'b0;
                end
                if (hs_ar) begin
                    have = 1'b1;
                    req_addr = ar_addr;
                    delay = int'($urandom_range(0, 2));
                end
                if (have && !m_axi_rvalid) begin
                    if (delay == 0) begin
                        m_axi_rvalid = 1'b1;
                        m_axi_rlast  = 1'b1;
                        m_axi_rdata  = mem64(req_addr);
                        m_axi_rresp  = fault_at(req_addr) ? 2'b10 : 2'b00;
                    end else begin
                        delay--;
                    end
                end
                m_axi_arready = !have && (($urandom % 4) != 0);
            end
        end
    end

    // Monitor and reference model: the next expected instruction is always the
    // architectural PC, which advances by 4 on a handshake and jumps on a redirect.
    logic [63:0] exp_q[$];
    logic        rst_flag = 1'b0;
    logic        prev_arvalid = 1'b0;
    logic        prev_arready = 1'b0;
    logic [63:0] prev_araddr = '0;
    int          idle_cnt = 0;
    logic [63:0] exp_pc, exp_data;
    logic [31:0] exp_instr;

    always @(negedge clk) begin
        if (rst_flag)
            check64("reset_state",
                    {35'd0, out_valid, m_axi_arvalid, m_axi_rready, out_fault, out_instr},
                    64'd0);
        if (rst_flag)
            check64("reset_out_pc", out_pc, 64'd0);
        rst_flag = reset;

        if (reset) begin
            exp_q.delete();
            exp_q.push_back(entry);
            idle_cnt = 0;
            prev_arvalid = 1'b0;
        end else begin
            idle_cnt++;
            if (idle_cnt == 150) begin
                total++; bad++;
                $display("FAIL liveness: got no out_valid for %0d cycles want fewer", idle_cnt);
            end
            if (out_valid) begin
                idle_cnt = 0;
                if (exp_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL scoreboard_empty: got out_pc %h want none", out_pc);
                end else begin
                    exp_pc    = exp_q[0];
                    exp_data  = mem64({exp_pc[63:3], 3'b000});
                    exp_instr = exp_pc[2] ? exp_data[63:32] : exp_data[31:0];
                    check64("out_pc", out_pc, exp_pc);
                    check64("out_instr", {32'd0, out_instr}, {32'd0, exp_instr});
                    check64("out_fault", {63'd0, out_fault}, {63'd0, fault_at(exp_pc)});
                    if (out_ready) begin
                        hs_count++;
                        void'(exp_q.pop_front());
                        exp_q.push_back(exp_pc + 64'd4);
                    end
                end
            end
            if (redirect_valid) begin
                exp_q.delete();
                exp_q.push_back({redirect_pc[63:2], 2'b00});
            end
            if (m_axi_arvalid) begin
                check64("ar_const",
                        {29'd0, m_axi_arid, m_axi_arlen, m_axi_arsize, m_axi_arburst,
                         m_axi_arlock, m_axi_arcache, m_axi_arprot},
                        {29'd0, 13'd0, 8'd0, 3'b011, 2'b01, 1'b0, 4'd0, 3'd0});
                check64("araddr_align", {61'd0, m_axi_araddr[2:0]}, 64'd0);
                if (prev_arvalid && !prev_arready)
                    check64("araddr_stable", m_axi_araddr, prev_araddr);
            end
            prev_arvalid = m_axi_arvalid;
            prev_arready = m_axi_arready;
            prev_araddr  = m_axi_araddr;
        end
    end

    // Stimulus: random backpressure and redirects, with one mid-run reset to an
    // entry point just below the top of the address space so pc+4 wraps.
    initial begin
        int r;
        reset = 1'b1;
        entry = 64'h0000_0000_8000_0000;
        out_ready = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        for (int c = 0; c < 4000; c++) begin
            @(posedge clk);
            #1;
            if (c >= 2000 && c < 2004) begin
                reset = 1'b1;
                entry = 64'hFFFF_FFFF_FFFF_FFE8;
                redirect_valid = 1'b0;
                out_ready = 1'b0;
            end else begin
                reset = 1'b0;
                out_ready = ($urandom % 4) != 0;
                redirect_valid = ($urandom % 16) == 0;
                r = int'($urandom_range(0, 2));
                if (r == 0)
                    redirect_pc = 64'h9000_0000 + 64'($urandom_range(0, 255));
                else if (r == 1)
                    redirect_pc = 64'h100 + 64'($urandom_range(0, 63));
                else
                    redirect_pc = 64'hFFFF_FFFF_FFFF_FFF0 + 64'($urandom_range(0, 15));
            end
        end
        @(negedge clk);
        total++;
        if (hs_count < 100) begin
            bad++;
            $display("FAIL handshake_count: got %0d want >= 100", hs_count);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
